// File: rtl/cordic_iter_sequencer_if.sv
// cordic_iter_sequencer_if: control/step bundle between CORDIC control and the iteration sequencer.
// The stall signal exists only when CORDIC_SEQ_STALL_EN is defined.
interface cordic_iter_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             abort;
    logic [1:0]       coordinate_system;
`ifdef CORDIC_SEQ_STALL_EN
    logic             stall;
`endif
    logic             busy;
    logic             step_vld;
    logic [IDX_W-1:0] shift_idx;
    logic             rep;
    logic             first;
    logic             last;
    logic             done;

    modport master (
        output start, abort, coordinate_system,
`ifdef CORDIC_SEQ_STALL_EN
        output stall,
`endif
        input  busy, step_vld, shift_idx, rep, first, last, done
    );

    modport slave (
        input  start, abort, coordinate_system,
`ifdef CORDIC_SEQ_STALL_EN
        input  stall,
`endif
        output busy, step_vld, shift_idx, rep, first, last, done
    );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer: per-step shift index sequencer for circular/linear/hyperbolic CORDIC.
// Optional CORDIC_SEQ_STALL_EN adds a stall input that freezes the sequence in RUN.
module cordic_iter_sequencer #(
    parameter int IDX_W  = 6,
    parameter int N_ITER = 16
) (
    input logic clk,
    input logic rst_n,
    cordic_iter_sequencer_if.slave sif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int TW = IDX_W + 2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [TW-1:0]    rep_tgt;
    logic             hyp;
    logic             rep_ph;
    logic             first_ph;
    logic             run;
    logic             stall_i;
    logic             adv;
    logic             dup;
    logic             is_last;
    logic [TW+1:0]    tgt_nxt;
    logic [TW-1:0]    tgt_sat;

`ifdef CORDIC_SEQ_STALL_EN
    assign stall_i = sif.stall;
`else
    assign stall_i = 1'b0;
`endif

    always_comb begin
        run     = state == S_RUN;
        adv     = run && !stall_i;
        dup     = hyp && ({2'b00, idx} == rep_tgt) && !rep_ph;
        is_last = hyp ? (idx == IDX_W'(N_ITER)) && !dup : idx == IDX_W'(N_ITER - 1);
        // 3k+1 computed two bits wider so overflow can be detected and saturated
        tgt_nxt = {2'b00, rep_tgt} + {1'b0, rep_tgt, 1'b0} + (TW + 2)'(1);
        tgt_sat = (tgt_nxt[TW+1:TW] != 2'b00) ? '1 : tgt_nxt[TW-1:0];
    end

    assign sif.busy      = run;
    assign sif.step_vld  = adv;
    assign sif.shift_idx = idx;
    assign sif.rep       = run && rep_ph;
    assign sif.first     = adv && first_ph;
    assign sif.last      = adv && is_last;
    assign sif.done      = state == S_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            rep_tgt  <= TW'(4);
            hyp      <= 1'b0;
            rep_ph   <= 1'b0;
            first_ph <= 1'b0;
        end else if (state == S_IDLE) begin
            if (sif.start && !sif.abort) begin
                state    <= S_RUN;
                hyp      <= sif.coordinate_system[1];
                idx      <= sif.coordinate_system[1] ? IDX_W'(1) : '0;
                rep_tgt  <= TW'(4);
                rep_ph   <= 1'b0;
                first_ph <= 1'b1;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end else if (sif.abort) begin
            state  <= S_IDLE;
            rep_ph <= 1'b0;
        end else if (adv) begin
            first_ph <= 1'b0;
            if (is_last) begin
                state <= S_DONE;
            end else if (dup) begin
                rep_ph <= 1'b1;
            end else begin
                idx    <= idx + 1'b1;
                rep_ph <= 1'b0;
                if (rep_ph) rep_tgt <= tgt_sat;
            end
        end
    end
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// tb_cordic_iter_sequencer: scoreboard bench; expected step list queued at start, checked per step_vld.
// A second instance with N_ITER=1 covers the single-step boundary.
module tb_cordic_iter_sequencer;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int nsteps = 0;
    int nbusy = 0;
    int nstall = 0;
    logic pend_done = 1'b0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    cordic_iter_sequencer_if #(.IDX_W(6)) sb();
    cordic_iter_sequencer_if #(.IDX_W(6)) s1();

    cordic_iter_sequencer #(.IDX_W(6), .N_ITER(N)) dut (.clk(clk), .rst_n(rst_n), .sif(sb));
    cordic_iter_sequencer #(.IDX_W(6), .N_ITER(1)) dut1 (.clk(clk), .rst_n(rst_n), .sif(s1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected {idx, rep, first, last} list for one full operation
    task automatic push_op(input logic hm);
        logic [8:0] v[$];
        int tgt = 4;
        for (int i = (hm ? 1 : 0); i <= (hm ? N : N - 1); i++) begin
            v.push_back({6'(i), 3'b000});
            if (hm && i == tgt) begin
                v.push_back({6'(i), 3'b100});
                tgt = 3 * tgt + 1;
            end
        end
        v[0][1] = 1'b1;
        v[v.size()-1][0] = 1'b1;
        foreach (v[k]) q.push_back(v[k]);
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic expect_run);
        nsteps = 0; nbusy = 0; nstall = 0;
        sb.coordinate_system = m;
        sb.start = 1'b1;
        if (expect_run) push_op(m[1]);
        @(posedge clk); #1;
        sb.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = sb.done;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        chk("done", sb.done, pend_done);
        pend_done = 1'b0;
        if (sb.busy) nbusy++;
        if (sb.busy && !sb.step_vld) nstall++;
        if (sb.step_vld) begin
            nsteps++;
            if (q.size() == 0) chk("extra_step", 1, 0);
            else begin
                e = q.pop_front();
                chk("step", {sb.shift_idx, sb.rep, sb.first, sb.last}, e);
                pend_done = e[0];
            end
        end
    end

    initial begin
        sb.start = 0; sb.abort = 0; sb.coordinate_system = 0;
        s1.start = 0; s1.abort = 0; s1.coordinate_system = 0;
`ifdef CORDIC_SEQ_STALL_EN
        sb.stall = 0; s1.stall = 0;
`endif
        #2;
        chk("reset_outs", {sb.busy, sb.step_vld, sb.shift_idx, sb.rep, sb.first, sb.last, sb.done}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // circular full run
        pulse_start(2'b00, 1);
        wait_done("circ");
        @(posedge clk); #1;
        chk("circ_steps", nsteps, N);
        chk("circ_busy", nbusy, N);
        chk("circ_q", q.size(), 0);

        // hyperbolic full run with repeats at 4 and 13
        pulse_start(2'b10, 1);
        wait_done("hyp");
        @(posedge clk); #1;
        chk("hyp_steps", nsteps, 18);
        chk("hyp_q", q.size(), 0);

        // linear, then start during DONE is ignored
        pulse_start(2'b01, 1);
        wait_done("lin");
        sb.start = 1'b1;
        @(posedge clk); #1;
        sb.start = 1'b0;
        @(negedge clk);
        chk("start_in_done", sb.busy, 0);
        @(posedge clk); #1;
        pulse_start(2'b01, 1);
        wait_done("lin2");
        @(posedge clk); #1;
        chk("lin2_steps", nsteps, N);

        // start+abort together in IDLE: abort wins
        sb.start = 1'b1; sb.abort = 1'b1;
        @(posedge clk); #1;
        sb.start = 1'b0; sb.abort = 1'b0;
        chk("start_abort_idle", sb.busy, 0);

        // hyperbolic abort on the 5th step, then restart repeats idx 4 again
        pulse_start(2'b10, 1);
        repeat (4) @(posedge clk);
        #1 sb.abort = 1'b1;
        @(posedge clk); #1;
        sb.abort = 1'b0;
        chk("abort_busy", sb.busy, 0);
        chk("abort_steps", nsteps, 5);
        q.delete();
        @(posedge clk); #1;
        pulse_start(2'b10, 1);
        wait_done("hyp_restart");
        @(posedge clk); #1;
        chk("restart_steps", nsteps, 18);

        // reset while idx 9 is on the bus
        pulse_start(2'b00, 1);
        repeat (9) @(posedge clk);
        #1 chk("pre_rst_idx", sb.shift_idx, 9);
        rst_n = 1'b0;
        #1 chk("mid_rst_outs", {sb.busy, sb.step_vld, sb.shift_idx, sb.rep, sb.first, sb.last, sb.done}, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(2'b01, 1);
        wait_done("post_rst");
        @(posedge clk); #1;
        chk("post_rst_steps", nsteps, N);

`ifdef CORDIC_SEQ_STALL_EN
        // stall three cycles while the repeated copy of idx 4 is pending
        pulse_start(2'b10, 1);
        repeat (4) @(posedge clk);
        #1 sb.stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 sb.stall = 1'b0;
        wait_done("stall");
        @(posedge clk); #1;
        chk("stall_cycles", nstall, 3);
        chk("stall_steps", nsteps, 18);
        chk("stall_busy", nbusy, 21);
`endif

        // N_ITER=1: single step with first=last, circular then hyperbolic
        for (int m = 0; m < 2; m++) begin
            s1.coordinate_system = m ? 2'b10 : 2'b00;
            s1.start = 1'b1;
            @(posedge clk); #1;
            s1.start = 1'b0;
            @(negedge clk);
            chk("n1_step", {s1.step_vld, s1.shift_idx, s1.rep, s1.first, s1.last}, {1'b1, 6'(m), 3'b011});
            @(negedge clk);
            chk("n1_done", {s1.done, s1.step_vld}, 2'b10);
            @(negedge clk);
            chk("n1_idle", {s1.busy, s1.done}, 2'b00);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
